cpu_mem_bridge: RTL
===================

Name: cpu_mem_bridge

Overview:
- Sits between the cpu_6502 bus and spi_sram_master: decodes each CPU access to one of three targets.
  - On-chip local RAM, for zero page and stack.
  - A 16-byte I/O register window.
  - External SPI SRAM, reached through the master.
- Generates CPU RDY and steers DI so that local and I/O accesses run at full speed; only SPI accesses stall the CPU.

Parameters:
LOCAL_AW, 9, local RAM address width; local region 0x0000..2^LOCAL_AW-1 (512 B).
IO_BASE, 16'hFE00, base of the 16-byte I/O window; low 4 bits must be 0.
SPI_BANK, 8'h00, drives mem_addr[23:16] on every SPI access.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
ab  in  16  CPU address
dout  in  8  CPU write data
we  in  1  CPU write strobe
din  out  8  CPU read data
rdy  out  1  CPU ready
mem_addr  out  24  to spi_sram_master: {SPI_BANK, ab}
mem_en  out  1  to master: request strobe
mem_wr  out  1  to master: write
mem_wdata  out  8  to master: write data
ready  in  1  from master: accept/complete
mem_rdata  in  8  from master: read data
port_out  out  8  I/O register 0 (test-code / LED port)

Behaviour:
- Access cycle: any cycle with rdy=1. The CPU presents ab/we/dout; the bridge commits the access.
  - rdy=0: the CPU holds ab/we/dout; the held value is the next, not-yet-issued access and must not be committed.
- Decode (combinational on ab):
  - LOCAL if ab < 2^LOCAL_AW.
  - IO if ab[15:4] == IO_BASE[15:4].
  - SPI otherwise.
- sel_q register: records the target of the last committed access. Loaded only on access cycles; held while rdy=0.
- rdy (combinational):
  - 1 when sel_q is LOCAL or IO.
  - Equal to `ready` when sel_q is SPI.
- din mux by sel_q:
  - LOCAL: registered local RAM read (1-cycle latency).
  - IO: registered I/O read.
  - SPI: mem_rdata passthrough.
- Master request:
  - mem_en = rdy & decode==SPI & rst_n.
  - mem_wr = we; mem_wdata = dout; mem_addr = {SPI_BANK, ab}.
  - The master accepts on mem_en & ready. Read data is valid on mem_rdata in the next cycle with ready=1. The completion cycle is itself an access cycle, so back-to-back SPI accesses chain with no idle cycle.
- Local RAM:
  - Write when access cycle & LOCAL & we.
  - Read-during-write returns the old data.
- I/O registers (offset ab[3:0]):
  - 0: port_out, R/W.
  - 1: status, RO, = {7'b0, ~ready}.
  - 2..5: cycle snapshot bytes 0..3, RO.
  - Reading offset 2 on an access cycle latches the current 32-bit free-running cycle counter into the snapshot; that read returns byte0 of the new value. Bytes 1..3 return the snapshot as held.
  - Offsets 6..15 read 8'h00; writes to RO and unused offsets are ignored.
- Cycle counter: 32-bit, increments every clock, wraps 0xFFFFFFFF -> 0.
- Writes return din = 8'h00 in the following cycle for LOCAL/IO; SPI writes return mem_rdata, don't care.
- Reset (rst_n=0 at a clk edge):
  - sel_q=LOCAL, so rdy=1 immediately after reset.
  - port_out=0, counter=0, snapshot=0, io/local read registers=0, mem_en=0.
  - Local RAM contents are not reset.
  - Reset during a pending SPI access abandons it; the master shares rst_n.
- Simultaneous events: a snapshot latch and a counter increment in the same cycle capture the pre-increment value.

Decomposition:
- Package cpu_mem_pkg holds:
  - the sel_t enum {SEL_LOCAL, SEL_IO, SEL_SPI};
  - I/O offset constants IO_PORT=0, IO_STATUS=1, IO_SNAP0..IO_SNAP3=2..5.
- Sub-module cpu_mem_local_ram: a synchronous single-port RAM, parameterised by LOCAL_AW.

Test Plan:
- Reset, then write 0x5A to 0x0010 and read it back -> rdy stays 1 throughout; din=0x5A one cycle after the read; mem_en never asserted.
- Read 0x1234 with the master model returning 0xC3 after 8 stall cycles -> mem_en pulses once, at ab=0x1234; rdy=0 for 8 cycles; din=0xC3 on the cycle rdy returns to 1; mem_addr=0x001234.
- Two back-to-back SPI reads, 0x4000 then 0x4001 -> the second mem_en coincides with the first completion cycle; no duplicate issue of 0x4001 during the stall.
- Write 0x07 to 0xFE00, then read 0xFE02..0xFE05 after 1000 cycles -> port_out=0x07; snapshot equals the counter at the 0xFE02 read cycle (±0), bytes consistent across the four reads.
- Assert rst_n=0 for 1 cycle mid SPI read -> the next cycle shows rdy=1, sel_q=LOCAL, port_out=0, mem_en=0.
- Run 6502_functional_test with 0x0000..0x01FF local and the rest over SPI -> PC reaches 0x3469; the test-code byte at 0x0200 is reached via the SPI path.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the 6502 memory bridge: target select enum,
// I/O register offsets and the address decode helper.
// Latency: none (types and a pure function). Backpressure: not applicable.
package cpu_mem_pkg;

    // Target of a CPU access.
    typedef enum logic [1:0] {
        SEL_LOCAL = 2'd0,
        SEL_IO    = 2'd1,
        SEL_SPI   = 2'd2
    } sel_t;

    // Offsets inside the 16-byte I/O window.
    localparam logic [3:0] IO_PORT   = 4'd0;
    localparam logic [3:0] IO_STATUS = 4'd1;
    localparam logic [3:0] IO_SNAP0  = 4'd2;
    localparam logic [3:0] IO_SNAP1  = 4'd3;
    localparam logic [3:0] IO_SNAP2  = 4'd4;
    localparam logic [3:0] IO_SNAP3  = 4'd5;

    // Local RAM occupies the bottom 2^local_aw bytes; the I/O window is
    // matched on the upper 12 address bits; everything else goes to SPI.
    function automatic sel_t decode_addr(input logic [15:0] addr,
                                         input int unsigned local_aw,
                                         input logic [15:0] io_base);
        sel_t sel;
        if ({16'd0, addr} < (32'd1 << local_aw)) begin
            sel = SEL_LOCAL;
        end else if (addr[15:4] == io_base[15:4]) begin
            sel = SEL_IO;
        end else begin
            sel = SEL_SPI;
        end
        return sel;
    endfunction

endpackage

// File: rtl/cpu_mem_local_ram.sv
// Synchronous single-port byte RAM for zero page and stack.
// Latency: 1 cycle read (registered output); read-during-write returns old data.
// Backpressure: none, accepts an access on every cycle with en_i=1.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (output register only)
//   en_i, we_i        access enable, write enable
//   addr_i, wdata_i   byte address and write data
//   rdata_o           registered read data
module cpu_mem_local_ram
    import cpu_mem_pkg::*;
#(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [0:(1<<AW)-1];
    logic [7:0] rdata_q;

    // Storage is deliberately not reset so it maps onto a RAM macro.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= 8'h00;
        end else if (en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_mem_bridge.sv
// Decodes each 6502 bus access to local RAM, the I/O window or SPI SRAM and
// drives RDY/DI so that local and I/O accesses run at full speed.
// Latency: local/IO read data 1 cycle; SPI read data on the cycle ready returns.
// Backpressure: CPU rdy follows the master's ready only while an SPI access is outstanding.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   ab, dout, we                 CPU address, write data, write strobe
//   din, rdy                     CPU read data and ready
//   mem_addr/en/wr/wdata         request to spi_sram_master
//   ready, mem_rdata             accept/complete and read data from the master
//   port_out                     I/O register 0
module cpu_mem_bridge
    import cpu_mem_pkg::*;
#(
    parameter int          LOCAL_AW = 9,
    parameter logic [15:0] IO_BASE  = 16'hFE00,
    parameter logic [7:0]  SPI_BANK = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ab,
    input  logic [7:0]  dout,
    input  logic        we,
    output logic [7:0]  din,
    output logic        rdy,
    output logic [23:0] mem_addr,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic        ready,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  port_out
);

    sel_t        dec;
    sel_t        sel_q, sel_d;
    logic        acc;
    logic [3:0]  io_off;

    logic [7:0]  port_q,  port_d;
    logic [31:0] cnt_q,   cnt_d;
    logic [31:0] snap_q,  snap_d;
    logic [7:0]  io_rd_q, io_rd_d;
    logic        lwr_q,   lwr_d;   // last local access was a write
    logic [7:0]  ram_rdata;

    assign dec    = decode_addr(ab, LOCAL_AW, IO_BASE);
    assign io_off = ab[3:0];

    // sel_q names the access still in flight; only SPI can hold the CPU.
    assign rdy = (sel_q == SEL_SPI) ? ready : 1'b1;

    // An access cycle commits the presented address. Gating with rst_n keeps
    // the held access from writing anything while reset is asserted.
    assign acc = rdy & rst_n;

    assign mem_en    = rdy & (dec == SEL_SPI) & rst_n;
    assign mem_wr    = we;
    assign mem_wdata = dout;
    assign mem_addr  = {SPI_BANK, ab};
    assign port_out  = port_q;

    cpu_mem_local_ram #(
        .AW (LOCAL_AW)
    ) u_local_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (acc && (dec == SEL_LOCAL)),
        .we_i    (we),
        .addr_i  (ab[LOCAL_AW-1:0]),
        .wdata_i (dout),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        sel_d   = sel_q;
        port_d  = port_q;
        snap_d  = snap_q;
        io_rd_d = io_rd_q;
        lwr_d   = lwr_q;
        cnt_d   = cnt_q + 32'd1;

        if (acc) begin
            sel_d = dec;
            lwr_d = we;
            if (dec == SEL_IO) begin
                if (we) begin
                    io_rd_d = 8'h00;
                    if (io_off == IO_PORT) begin
                        port_d = dout;
                    end
                end else begin
                    case (io_off)
                        IO_PORT:   io_rd_d = port_q;
                        IO_STATUS: io_rd_d = {7'b0, ~ready};
                        // Latch the pre-increment count and return its low
                        // byte in the same read, so the four bytes agree.
                        IO_SNAP0: begin
                            snap_d  = cnt_q;
                            io_rd_d = cnt_q[7:0];
                        end
                        IO_SNAP1:  io_rd_d = snap_q[15:8];
                        IO_SNAP2:  io_rd_d = snap_q[23:16];
                        IO_SNAP3:  io_rd_d = snap_q[31:24];
                        default:   io_rd_d = 8'h00;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q   <= SEL_LOCAL;
            port_q  <= 8'h00;
            cnt_q   <= 32'd0;
            snap_q  <= 32'd0;
            io_rd_q <= 8'h00;
            lwr_q   <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            port_q  <= port_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            io_rd_q <= io_rd_d;
            lwr_q   <= lwr_d;
        end
    end

    // A local write returns zero; the RAM itself still reports the old byte.
    always_comb begin
        din = 8'h00;
        case (sel_q)
            SEL_LOCAL: din = lwr_q ? 8'h00 : ram_rdata;
            SEL_IO:    din = io_rd_q;
            SEL_SPI:   din = mem_rdata;
            default:   din = 8'h00;
        endcase
    end

endmodule
